gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Write-side front end of the GPR file: the single block that drives the register file write port (regWrite, rw, Wd).
- Merges two write sources:
  - in-order pipeline WB writes, which always win;
  - results from the long-latency unit (mult/div/load-miss), which are buffered in a small FIFO with a valid/ready handshake.
- Exposes a query port so ID can forward write data that is still pending.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, min 2)
AW, 2, log2(DEPTH) pointer width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous active-low reset; sampled on posedge clk, state cleared while low
wb_en  in  1  pipeline WB write request this cycle (no stall, always accepted)
wb_rw  in  5  pipeline WB destination register
wb_data  in  32  pipeline WB data
lu_valid  in  1  long-latency result valid
lu_rw  in  5  long-latency destination register
lu_data  in  32  long-latency data
lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready at posedge
regWrite  out  1  registered GPR write enable
rw  out  5  registered GPR write address
Wd  out  32  registered GPR write data
q_reg  in  5  ID read address to check for pending writes
q_hit  out  1  q_reg has a pending or in-flight write
q_data  out  32  youngest pending data for q_reg
pend_cnt  out  AW+1  valid FIFO occupancy

Behaviour:
Reset:
- While reset==0 at posedge: regWrite=0, rw=0, Wd=0; FIFO pointers, count and all entry valid bits cleared.
- lu_ready is forced 0 combinationally while reset==0.
- A reset applied mid-transfer discards all queued results; nothing is written after reset.

Output register (updated at each posedge, priority order):
1. wb_en && wb_rw!=0: regWrite=1, rw=wb_rw, Wd=wb_data.
2. Else, FIFO head valid and not killed: regWrite=1, rw=head.rw, Wd=head.data; pop.
3. Else: regWrite=0; rw and Wd hold their previous values.
- A killed head is popped silently. This consumes the cycle: no write that cycle.

Latency:
- Pipeline write appears on regWrite exactly 1 cycle after wb_en.
- An LU result pushed at edge N is issued at edge N+1 at the earliest, if no wb_en at that edge.

Register $0:
- Writes to $0 from either source are dropped.
- wb_en with wb_rw==0 counts as "no pipeline write", so the FIFO may drain that cycle.
- LU push with lu_rw==0 is accepted (handshake completes) but not enqueued.

FIFO:
- lu_ready = reset && (pend_cnt < DEPTH). It is based on occupancy only; a same-cycle pop does not create room.
- Push and pop in the same cycle are allowed when not full: count unchanged, pointers wrap modulo DEPTH.
- pend_cnt counts stored entries, including killed ones not yet popped.

Kill rule:
- When the pipeline writes register R (case 1), every valid FIFO entry with rw==R is marked killed in the same edge. The pipeline write is younger in program order.
- An LU result pushed in that same edge with lu_rw==R is not killed.

Query (combinational):
- q_reg==0: q_hit=0, q_data=0.
- Otherwise, search in order:
  1. youngest un-killed FIFO entry with rw==q_reg;
  2. the output register if regWrite && rw==q_reg.
- No match: q_hit=0, q_data=0.

Optional Feature:
WB_FWD_EN:
- Defined: query logic as above.
- Undefined: q_hit and q_data are tied to 0 and the search logic is removed. Ports remain.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_en=1, lu_valid=1 -> regWrite=0, rw=0, Wd=0, lu_ready=0, pend_cnt=0; release -> lu_ready=1.
- Pipeline write: wb_en=1, wb_rw=5, wb_data=0x1234 at edge N -> regWrite=1, rw=5, Wd=0x1234 after edge N; wb_rw=0 -> regWrite=0.
- LU drain under contention: push lu_rw=3/0xAA, lu_rw=4/0xBB while wb_en=1 (wb_rw=7, 8) for 2 cycles, then wb_en=0 -> writes 7, 8, 3, 4 in that order; pend_cnt returns to 0.
- Full/backpressure: with wb_en=1 continuously, push 4 entries -> pend_cnt=4, lu_ready=0; 5th lu_valid is not accepted; drop wb_en -> one pop per cycle; lu_ready=1 after the first pop.
- Kill: FIFO holds rw=9/0x11; pipeline writes rw=9/0x22 -> Wd=0x22; later head pop gives regWrite=0 for that cycle; GPR 9 ends at 0x22.
- Forwarding (WB_FWD_EN defined): FIFO holds rw=6/0x1, then rw=6/0x2; q_reg=6 -> q_hit=1, q_data=0x2; q_reg=0 -> q_hit=0. Macro undefined -> q_hit=0 always.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Write-side front end of the GPR file. Merges in-order pipeline WB writes
//   (always accepted, highest priority) with results from the long-latency
//   unit, which are queued in a small FIFO behind a valid/ready handshake.
//   A query port lets ID forward data that is still pending.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   wb_en/wb_rw/wb_data   pipeline write request
//   lu_valid/lu_rw/lu_data/lu_ready   long-latency result handshake
//   regWrite/rw/Wd        registered GPR write port
//   q_reg/q_hit/q_data    pending-write query (combinational)
//   pend_cnt              FIFO occupancy, killed entries included
//
// Build option
//   WB_FWD_EN  when defined, the query search is built; otherwise q_hit and
//              q_data are tied to zero.
module gpr_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [4:0]    wb_rw,
    input  logic [31:0]   wb_data,
    input  logic          lu_valid,
    input  logic [4:0]    lu_rw,
    input  logic [31:0]   lu_data,
    output logic          lu_ready,
    output logic          regWrite,
    output logic [4:0]    rw,
    output logic [31:0]   Wd,
    input  logic [4:0]    q_reg,
    output logic          q_hit,
    output logic [31:0]   q_data,
    output logic [AW:0]   pend_cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       ent_rw   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_kill;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic wb_go;
    logic push;
    logic enq;
    logic pop;
    logic head_kill;

    assign pend_cnt  = count;
    assign lu_ready  = reset && (count < FULL);
    // A write to $0 is not a pipeline write, so the FIFO may drain instead.
    assign wb_go     = wb_en && (wb_rw != 5'd0);
    assign push      = lu_valid && lu_ready;
    // $0 results complete the handshake but are never stored.
    assign enq       = push && (lu_rw != 5'd0);
    assign pop       = !wb_go && (count != '0);
    assign head_kill = ent_kill[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            regWrite  <= 1'b0;
            rw        <= 5'd0;
            Wd        <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_kill  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rw[i]   <= 5'd0;
                ent_data[i] <= 32'd0;
            end
        end else begin
            if (wb_go) begin
                regWrite <= 1'b1;
                rw       <= wb_rw;
                Wd       <= wb_data;
                // Queued results for the same register are older than this
                // write and must never reach the register file.
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && (ent_rw[i] == wb_rw))
                        ent_kill[i] <= 1'b1;
                end
            end else if (pop) begin
                // A killed head still takes its slot this cycle.
                regWrite <= !head_kill;
                if (!head_kill) begin
                    rw <= ent_rw[rd_ptr];
                    Wd <= ent_data[rd_ptr];
                end
                ent_valid[rd_ptr] <= 1'b0;
                ent_kill[rd_ptr]  <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end else begin
                regWrite <= 1'b0;
            end

            // Placed after the kill loop so a same-edge push is never killed.
            if (enq) begin
                ent_rw[wr_ptr]    <= lu_rw;
                ent_data[wr_ptr]  <= lu_data;
                ent_valid[wr_ptr] <= 1'b1;
                ent_kill[wr_ptr]  <= 1'b0;
                wr_ptr            <= wr_ptr + 1'b1;
            end

            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FWD_EN
    logic [AW-1:0] idx;

    // Walk oldest to youngest so the youngest live match wins; any FIFO match
    // overrides the output register.
    always_comb begin
        q_hit  = 1'b0;
        q_data = 32'd0;
        idx    = '0;
        if (q_reg != 5'd0) begin
            if (regWrite && (rw == q_reg)) begin
                q_hit  = 1'b1;
                q_data = Wd;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + AW'(i);
                if (((AW+1)'(i) < count) && ent_valid[idx] && !ent_kill[idx]
                    && (ent_rw[idx] == q_reg)) begin
                    q_hit  = 1'b1;
                    q_data = ent_data[idx];
                end
            end
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q_reg;
    assign q_hit    = 1'b0;
    assign q_data   = 32'd0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_en;
    logic [4:0]    wb_rw;
    logic [31:0]   wb_data;
    logic          lu_valid;
    logic [4:0]    lu_rw;
    logic [31:0]   lu_data;
    logic          lu_ready;
    logic          regWrite;
    logic [4:0]    rw;
    logic [31:0]   Wd;
    logic [4:0]    q_reg;
    logic          q_hit;
    logic [31:0]   q_data;
    logic [AW:0]   pend_cnt;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wb_en(wb_en), .wb_rw(wb_rw), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_rw(lu_rw), .lu_data(lu_data), .lu_ready(lu_ready),
        .regWrite(regWrite), .rw(rw), .Wd(Wd),
        .q_reg(q_reg), .q_hit(q_hit), .q_data(q_data),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] data;
        bit          k;
    } ent_t;

    ent_t        mq[$];
    bit          m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_wd;
    logic [31:0] gpr [32];
    bit          warm = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational outputs against the
    // model's pre-edge state, advance the model, check registered outputs.
    task automatic step(input bit rst, input bit we, input logic [4:0] wr,
                        input logic [31:0] wd, input bit lv, input logic [4:0] lr,
                        input logic [31:0] ld, input logic [4:0] qr);
        bit          exp_rdy;
        bit          exp_hit;
        logic [31:0] exp_qd;
        ent_t        e;
        @(negedge clk);
        reset = rst; wb_en = we; wb_rw = wr; wb_data = wd;
        lu_valid = lv; lu_rw = lr; lu_data = ld; q_reg = qr;
        #1;
        exp_rdy = rst && (mq.size() < DEPTH);
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, exp_rdy});
        if (warm) begin
            exp_hit = 0;
            exp_qd  = 32'd0;
`ifdef WB_FWD_EN
            if (qr != 5'd0) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (!exp_hit && !mq[i].k && mq[i].rw == qr) begin
                        exp_hit = 1;
                        exp_qd  = mq[i].data;
                    end
                end
                if (!exp_hit && m_we && m_rw == qr) begin
                    exp_hit = 1;
                    exp_qd  = m_wd;
                end
            end
`endif
            chk("q_hit", {31'd0, q_hit}, {31'd0, exp_hit});
            chk("q_data", q_data, exp_qd);
        end

        if (!rst) begin
            mq.delete();
            m_we = 0; m_rw = 5'd0; m_wd = 32'd0;
        end else begin
            if (we && wr != 5'd0) begin
                m_we = 1; m_rw = wr; m_wd = wd;
                foreach (mq[i]) if (mq[i].rw == wr) mq[i].k = 1;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = !e.k;
                if (!e.k) begin m_rw = e.rw; m_wd = e.data; end
            end else begin
                m_we = 0;
            end
            if (lv && exp_rdy && lr != 5'd0) begin
                e.rw = lr; e.data = ld; e.k = 0;
                mq.push_back(e);
            end
            if (m_we) gpr[m_rw] = m_wd;
        end

        @(posedge clk);
        #1;
        chk("regWrite", {31'd0, regWrite}, {31'd0, m_we});
        chk("rw", {27'd0, rw}, {27'd0, m_rw});
        chk("Wd", Wd, m_wd);
        chk("pend_cnt", {29'd0, pend_cnt}, mq.size());
        if (!rst) warm = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        reset = 0; wb_en = 0; wb_rw = 0; wb_data = 0;
        lu_valid = 0; lu_rw = 0; lu_data = 0; q_reg = 0;

        // Reset held with activity on both sources
        step(0, 1, 5'd5, 32'hDEAD, 1, 5'd3, 32'hBEEF, 5'd0);
        step(0, 1, 5'd5, 32'hDEAD, 1, 5'd3, 32'hBEEF, 5'd0);
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_pend", {29'd0, pend_cnt}, 32'd0);
        @(negedge clk);
        reset = 1; wb_en = 0; lu_valid = 0;
        #1;
        chk("rst_release_ready", {31'd0, lu_ready}, 32'd1);

        // Pipeline write, then a $0 write
        step(1, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 5'd5);
        chk("wb_rw5", {27'd0, rw}, 32'd5);
        chk("wb_data5", Wd, 32'h1234);
        step(1, 1, 5'd0, 32'h9999, 0, 5'd0, 32'd0, 5'd5);
        chk("wb_r0_nowrite", {31'd0, regWrite}, 32'd0);

        // LU drain under contention: expect writes 7, 8, 3, 4
        step(1, 1, 5'd7, 32'h70, 1, 5'd3, 32'hAA, 5'd3);
        step(1, 1, 5'd8, 32'h80, 1, 5'd4, 32'hBB, 5'd4);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3);
        chk("drain_first", {27'd0, rw}, 32'd3);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        chk("drain_second", Wd, 32'hBB);
        idle(1);
        chk("drain_empty", {29'd0, pend_cnt}, 32'd0);

        // Fill to full while the pipeline keeps writing, then drain
        for (int i = 0; i < 5; i++)
            step(1, 1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 32'(32'h100 + i), 5'd11);
        chk("full_cnt", {29'd0, pend_cnt}, 32'd4);
        chk("full_ready", {31'd0, lu_ready}, 32'd0);
        idle(5);

        // Kill: queued 9/0x11 overtaken by pipeline 9/0x22
        step(1, 1, 5'd12, 32'h12, 1, 5'd9, 32'h11, 5'd9);
        step(1, 1, 5'd9, 32'h22, 0, 5'd0, 32'd0, 5'd9);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd9);
        chk("kill_nowrite", {31'd0, regWrite}, 32'd0);
        chk("kill_gpr9", gpr[9], 32'h22);
        idle(1);

        // Forwarding: two pending writes to 6, youngest wins
        step(1, 1, 5'd13, 32'h13, 1, 5'd6, 32'h1, 5'd6);
        step(1, 1, 5'd14, 32'h14, 1, 5'd6, 32'h2, 5'd6);
        step(1, 1, 5'd15, 32'h15, 0, 5'd0, 32'd0, 5'd6);
        step(1, 1, 5'd16, 32'h16, 0, 5'd0, 32'd0, 5'd0);
        idle(3);

        // Randomized traffic on a small register range to provoke kills/hits
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
